trace_cmd_sequencer: RTL and testbench
======================================

# trace_cmd_sequencer

Upstream feeder for the L2 cache model. Accepts decoded trace-file records (command code + 32-bit address) over a valid/ready handshake and buffers them in a small FIFO. Issues them to the cache one at a time, waiting for completion before the next. Turns clear/print commands into one-cycle strobes and keeps the hit/miss/read/write statistics the simulation reports.

## Interface
- `I_SIZE`, 32, address width; matches the cache instruction width
- `FIFO_DEPTH`, 4, trace record buffer entries; power of 2, ≥2
- `CNT_W`, 32, width of each statistics counter
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `trc_valid`  in  1  trace record present
- `trc_ready`  out  1  FIFO can accept a record
- `trc_cmd`  in  4  trace command code
- `trc_addr`  in  I_SIZE  trace address
- `cache_valid`  out  1  request to cache valid
- `cache_ready`  in  1  cache accepts request
- `command`  out  4  command code to cache (zero-extended at the cache's integer input)
- `instruction`  out  I_SIZE  address to cache
- `cache_done`  in  1  cache finished current request (1-cycle pulse)
- `hit`  in  1  hit result, valid with `cache_done`
- `clear_req`  out  1  one-cycle strobe: clear cache and state
- `print_req`  out  1  one-cycle strobe: print cache contents
- `reads`, `writes`, `hits`, `misses`, `bad_cmds`  out  CNT_W each  statistics
- `idle`  out  1  FIFO empty and FSM in IDLE

## Operation
- Command codes:
  - 0: L1 data read; 1: L1 data write; 2: instruction fetch. All are "CPU" commands.
  - 3: L2 invalidate; 4: snooped read; 5: snooped write; 6: snooped RWIM. All are "snoop" commands.
  - 8: clear. 9: print. 7 and 10–15: illegal.
- FIFO push when `trc_valid && trc_ready`. `trc_ready = !full`, with no push-through on full even if a pop happens the same cycle.
- FSM states: IDLE, ISSUE, WAIT, CLEAR, PRINT.
  - IDLE, FIFO non-empty: pop head, load `command` and `instruction` registers.
    - CPU or snoop command → ISSUE.
    - Command 8 → CLEAR.
    - Command 9 → PRINT.
    - Illegal command → `bad_cmds`+1, stay in IDLE.
  - ISSUE: `cache_valid`=1 with `command` and `instruction` held stable. When `cache_ready` → WAIT.
  - WAIT: `cache_valid`=0. On `cache_done`:
    - CPU command: `reads`+1 for cmd 0 or 2, `writes`+1 for cmd 1; then `hits`+1 if `hit`, else `misses`+1.
    - Snoop command: no counter changes.
    - Next state IDLE.
  - CLEAR: `clear_req`=1 for exactly one cycle; all five counters go to 0 on that edge. → IDLE.
  - PRINT: `print_req`=1 for exactly one cycle, counters unchanged. → IDLE.
- `cache_done` outside WAIT is ignored.
- Counters saturate at all-ones; no wrap.
- Reset values: FIFO empty, state IDLE.
  - Outputs low: `cache_valid`, `clear_req`, `print_req`.
  - Outputs zero: `command`, `instruction`, all counters.
  - `trc_ready`=1, `idle`=1.
- Reset mid-operation (any state): pending FIFO entries are discarded and the in-flight request is abandoned. `cache_valid` drops in the cycle after the reset edge.

## Timing
- Record accepted at edge N. With FSM idle and FIFO previously empty:
  - Pop at edge N+1.
  - `cache_valid` high from N+2 onward.
- Minimum request period is 3 cycles for a CPU or snoop command: pop, issue handshake, done.
- Clear and print take 2 cycles each: pop, then strobe.
- `trc_ready` falls in the cycle after the push that fills the FIFO.
- If `cache_ready` and `cache_done` are both high in ISSUE, the request is only accepted in that cycle. `cache_done` is honoured only from WAIT, at least one cycle after acceptance.
- All outputs are registered. None depends combinationally on inputs.

## Structure
- Shared package `cache_pkg`:
  - `cmd_e` enum holding the codes above.
  - `is_cpu_cmd()` and `is_snoop_cmd()` functions.
  - Default `I_SIZE`.
- Sub-module `trace_fifo`: parameterised synchronous FIFO with full/empty flags, pointer wrap via extra MSB.
- FSM and counters live in the top module.

## Test plan
- Reset then single record cmd 0, addr 0x1000_0040; cache accepts, `cache_done` with `hit`=0 → `cache_valid` high 2 cycles after accept with `instruction`=0x1000_0040; `reads`=1, `misses`=1.
- Four back-to-back records (cmd 1, 2, 4, 1) with cache stalling `cache_ready` low for 5 cycles → FIFO fills, `trc_ready`=0; records issue in order; `writes`=2, `reads`=1; snoop cmd 4 leaves `hits`/`misses` unchanged.
- After 3 hits, record cmd 8 → `clear_req` single-cycle pulse; all counters 0 the next cycle; no `cache_valid`.
- Records cmd 9, then cmd 7, then cmd 15 → one `print_req` pulse; `bad_cmds`=2; nothing issued to the cache.
- Assert `reset` while in WAIT with 2 entries queued → next cycle `idle`=1, `trc_ready`=1, all counters 0, and a later `cache_done` has no effect.
- Force `hits` to all-ones, then one hit → `hits` stays all-ones.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared trace command definitions for the L2 cache model and its feeder.
package cache_pkg;

  localparam int DEF_I_SIZE = 32;

  typedef enum logic [3:0] {
    CMD_L1_RD    = 4'd0,
    CMD_L1_WR    = 4'd1,
    CMD_IFETCH   = 4'd2,
    CMD_L2_INV   = 4'd3,
    CMD_SNP_RD   = 4'd4,
    CMD_SNP_WR   = 4'd5,
    CMD_SNP_RWIM = 4'd6,
    CMD_CLEAR    = 4'd8,
    CMD_PRINT    = 4'd9
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_PRINT = 3'd4
  } seq_state_e;

  function automatic logic is_cpu_cmd(input logic [3:0] c);
    return (c <= 4'd2);
  endfunction

  function automatic logic is_snoop_cmd(input logic [3:0] c);
    return (c >= 4'd3) && (c <= 4'd6);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; pointers carry an extra MSB so that
// full and empty are distinguishable without a separate occupancy counter.
module trace_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Read and write pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/trace_cmd_sequencer.sv
// Buffers decoded trace records, issues them to the cache one at a time,
// turns clear/print into strobes and keeps saturating hit/miss statistics.
module trace_cmd_sequencer
  import cache_pkg::*;
#(
  parameter int I_SIZE     = DEF_I_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_valid,
  output logic              trc_ready,
  input  logic [3:0]        trc_cmd,
  input  logic [I_SIZE-1:0] trc_addr,
  output logic              cache_valid,
  input  logic              cache_ready,
  output logic [3:0]        command,
  output logic [I_SIZE-1:0] instruction,
  input  logic              cache_done,
  input  logic              hit,
  output logic              clear_req,
  output logic              print_req,
  output logic [CNT_W-1:0]  reads,
  output logic [CNT_W-1:0]  writes,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  bad_cmds,
  output logic              idle
);

  localparam int DW = 4 + I_SIZE;

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic              w_pop;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic              w_illegal;
  logic [DW-1:0]     w_head;
  logic [3:0]        w_head_cmd;
  logic [I_SIZE-1:0] w_head_addr;

  logic              r_cache_valid;
  logic              r_clear_req;
  logic              r_print_req;
  logic [3:0]        r_command;
  logic [I_SIZE-1:0] r_instruction;
  logic [CNT_W-1:0]  r_reads;
  logic [CNT_W-1:0]  r_writes;
  logic [CNT_W-1:0]  r_hits;
  logic [CNT_W-1:0]  r_misses;
  logic [CNT_W-1:0]  r_bad_cmds;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_push      = trc_valid && !w_full;
  assign w_head_cmd  = w_head[DW-1 -: 4];
  assign w_head_addr = w_head[I_SIZE-1:0];
  assign w_illegal   = !is_cpu_cmd(w_head_cmd) && !is_snoop_cmd(w_head_cmd) &&
                       (w_head_cmd != CMD_CLEAR) && (w_head_cmd != CMD_PRINT);

  trace_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({trc_cmd, trc_addr}),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Next-state and pop decision
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (is_cpu_cmd(w_head_cmd) || is_snoop_cmd(w_head_cmd)) begin
            w_next = ST_ISSUE;
          end else if (w_head_cmd == CMD_CLEAR) begin
            w_next = ST_CLEAR;
          end else if (w_head_cmd == CMD_PRINT) begin
            w_next = ST_PRINT;
          end else begin
            w_next = ST_IDLE;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cache_ready) w_next = ST_WAIT;
        else             w_next = ST_ISSUE;
      end
      ST_WAIT: begin
        if (cache_done) w_next = ST_IDLE;
        else            w_next = ST_WAIT;
      end
      ST_CLEAR: w_next = ST_IDLE;
      ST_PRINT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register and registered request/strobe outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cache_valid <= 1'b0;
      r_clear_req   <= 1'b0;
      r_print_req   <= 1'b0;
      r_command     <= 4'd0;
      r_instruction <= {I_SIZE{1'b0}};
    end else begin
      r_state       <= w_next;
      r_cache_valid <= (w_next == ST_ISSUE);
      r_clear_req   <= (w_next == ST_CLEAR);
      r_print_req   <= (w_next == ST_PRINT);
      if (w_pop) begin
        r_command     <= w_head_cmd;
        r_instruction <= w_head_addr;
      end
    end
  end

  // Statistics; snoop completions deliberately leave every counter untouched
  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_CLEAR)) begin
      r_reads    <= {CNT_W{1'b0}};
      r_writes   <= {CNT_W{1'b0}};
      r_hits     <= {CNT_W{1'b0}};
      r_misses   <= {CNT_W{1'b0}};
      r_bad_cmds <= {CNT_W{1'b0}};
    end else begin
      if (w_pop && w_illegal) r_bad_cmds <= sat_inc(r_bad_cmds);
      if ((r_state == ST_WAIT) && cache_done && is_cpu_cmd(r_command)) begin
        if (r_command == CMD_L1_WR) r_writes <= sat_inc(r_writes);
        else                        r_reads  <= sat_inc(r_reads);
        if (hit) r_hits   <= sat_inc(r_hits);
        else     r_misses <= sat_inc(r_misses);
      end
    end
  end

  assign trc_ready   = !w_full;
  assign idle        = w_empty && (r_state == ST_IDLE);
  assign cache_valid = r_cache_valid;
  assign clear_req   = r_clear_req;
  assign print_req   = r_print_req;
  assign command     = r_command;
  assign instruction = r_instruction;
  assign reads       = r_reads;
  assign writes      = r_writes;
  assign hits        = r_hits;
  assign misses      = r_misses;
  assign bad_cmds    = r_bad_cmds;

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// Randomised bench for trace_cmd_sequencer against a record-queue reference model.
module tb_trace_cmd_sequencer;
  localparam int CW   = 8;
  localparam int MAXC = 255;

  logic          clk = 1'b0;
  logic          reset, trc_valid, trc_ready, cache_valid, cache_ready;
  logic [3:0]    trc_cmd, command;
  logic [31:0]   trc_addr, instruction;
  logic          cache_done, hit, clear_req, print_req, idle;
  logic [CW-1:0] reads, writes, hits, misses, bad_cmds;

  trace_cmd_sequencer #(.I_SIZE(32), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_cmd(trc_cmd), .trc_addr(trc_addr), .cache_valid(cache_valid),
    .cache_ready(cache_ready), .command(command), .instruction(instruction),
    .cache_done(cache_done), .hit(hit), .clear_req(clear_req), .print_req(print_req),
    .reads(reads), .writes(writes), .hits(hits), .misses(misses),
    .bad_cmds(bad_cmds), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: records in arrival order plus the expected statistics
  logic [35:0] mq[$];
  bit          inflight = 0;
  logic [3:0]  inflight_cmd;
  int          m_reads, m_writes, m_hits, m_misses, m_bad, exp_clr, exp_prt, obs_clr, obs_prt;
  // cache responder knobs
  bit stall = 0, rdy_all = 0, spur_en = 0, hold_done = 0;
  int hit_mode = 2, done_cnt = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  function automatic bit issuable(input logic [3:0] c);
    return c <= 4'd6;
  endfunction

  task automatic model_reset();
    mq.delete();
    inflight = 0;
    m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_bad = 0;
    exp_clr = 0; exp_prt = 0; obs_clr = 0; obs_prt = 0;
  endtask

  // apply a record that never reaches the cache
  task automatic apply_ctrl(input logic [3:0] c);
    if (c == 4'd8) begin
      m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_bad = 0;
      exp_clr++;
    end else if (c == 4'd9) exp_prt++;
    else m_bad = sat(m_bad);
  endtask

  task automatic expect_issue(input logic [3:0] pcmd, input logic [31:0] pins);
    logic [35:0] rec;
    while (mq.size() > 0 && !issuable(mq[0][35:32])) begin
      rec = mq.pop_front();
      apply_ctrl(rec[35:32]);
    end
    if (mq.size() == 0) begin
      check_eq("unexpected_issue", {pcmd, pins}, 36'h0);
      inflight_cmd = 4'd3;
    end else begin
      rec = mq.pop_front();
      check_eq("issue_cmd", pcmd, rec[35:32]);
      check_eq("issue_addr", pins, rec[31:0]);
      inflight_cmd = rec[35:32];
    end
  endtask

  task automatic apply_done(input logic h);
    if (inflight_cmd <= 4'd2) begin
      if (inflight_cmd == 4'd1) m_writes = sat(m_writes);
      else                      m_reads  = sat(m_reads);
      if (h) m_hits = sat(m_hits);
      else   m_misses = sat(m_misses);
    end
  endtask

  // one clock: update the model from pre-edge values, then drive the cache side
  task automatic step();
    logic pre_ready, pre_cv;
    logic [3:0]  pcmd;
    logic [31:0] pins;
    pre_ready = trc_ready; pre_cv = cache_valid; pcmd = command; pins = instruction;
    if (reset) model_reset();
    else begin
      if (inflight && cache_done) begin
        apply_done(hit);
        inflight = 0;
      end
      if (pre_cv && cache_ready) begin
        expect_issue(pcmd, pins);
        inflight = 1;
        done_cnt = $urandom_range(1, 4);
      end
      if (trc_valid && pre_ready) mq.push_back({trc_cmd, trc_addr});
    end
    @(posedge clk);
    #1;
    if (clear_req) obs_clr++;
    if (print_req) obs_prt++;
    cache_ready = !stall && (rdy_all || ($urandom_range(0, 3) != 0));
    cache_done  = 1'b0;
    hit         = 1'($urandom_range(0, 1));
    if (inflight) begin
      if (!hold_done) begin
        if (done_cnt <= 1) begin
          cache_done = 1'b1;
          hit = (hit_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(hit_mode);
        end else done_cnt--;
      end
    end else if (spur_en) cache_done = ($urandom_range(0, 7) == 0);
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a);
    bit acc = 0;
    trc_valid = 1'b1; trc_cmd = c; trc_addr = a;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = trc_ready;
      step();
    end
    if (!acc) check_eq("push_timeout", 0, 1);
    trc_valid = 1'b0;
  endtask

  // run until everything is processed, then compare the model to the DUT
  task automatic settle(input string tag);
    bit done_ok = 0;
    logic [35:0] rec;
    trc_valid = 1'b0;
    for (int i = 0; i < 400 && !done_ok; i++) begin
      step();
      done_ok = idle && !inflight && !cache_valid && !clear_req && !print_req;
    end
    if (!done_ok) check_eq({tag, "_timeout"}, 0, 1);
    while (mq.size() > 0) begin
      rec = mq.pop_front();
      if (issuable(rec[35:32])) check_eq({tag, "_not_issued"}, {rec[35:32], rec[31:0]}, 36'h0);
      else apply_ctrl(rec[35:32]);
    end
    check_eq({tag, "_reads"},    reads,    m_reads);
    check_eq({tag, "_writes"},   writes,   m_writes);
    check_eq({tag, "_hits"},     hits,     m_hits);
    check_eq({tag, "_misses"},   misses,   m_misses);
    check_eq({tag, "_bad_cmds"}, bad_cmds, m_bad);
    check_eq({tag, "_clear_pulses"}, obs_clr, exp_clr);
    check_eq({tag, "_print_pulses"}, obs_prt, exp_prt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trc_valid = 1'b0; trc_cmd = 4'd0; trc_addr = 32'd0;
    cache_ready = 1'b0; cache_done = 1'b0; hit = 1'b0;
    model_reset();
    #1;
    do_reset();
    check_eq("rst_trc_ready", trc_ready, 1);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_cache_valid", cache_valid, 0);
    check_eq("rst_strobes", {clear_req, print_req}, 0);
    check_eq("rst_cmd_instr", {command, instruction}, 36'h0);
    check_eq("rst_counters", {reads, writes, hits, misses, bad_cmds}, 40'h0);

    // single read miss and its issue latency
    rdy_all = 1; hit_mode = 0;
    push(4'd0, 32'h1000_0040);
    check_eq("lat_cv_after_push", cache_valid, 0);
    step();
    check_eq("lat_cv_after_pop", cache_valid, 1);
    check_eq("lat_instr", instruction, 32'h1000_0040);
    settle("single");
    check_eq("single_reads_abs", reads, 1);
    check_eq("single_misses_abs", misses, 1);

    // fill the FIFO behind a stalled cache
    stall = 1; hit_mode = 2;
    push(4'd1, 32'hA000_0000); push(4'd2, 32'hA000_0004); push(4'd4, 32'hA000_0008);
    push(4'd1, 32'hA000_000C); push(4'd0, 32'hA000_0010);
    check_eq("full_trc_ready", trc_ready, 0);
    trc_valid = 1'b1; trc_cmd = 4'd3; trc_addr = 32'hDEAD_BEEF;
    step(); step(); step();
    check_eq("full_hold_ready", trc_ready, 0);
    check_eq("stall_cv", cache_valid, 1);
    check_eq("stall_cmd", command, 1);
    trc_valid = 1'b0; stall = 0;
    settle("fill");
    check_eq("fill_writes_abs", writes, 2);
    check_eq("fill_rw_total", reads, 3);

    // clear after hits
    hit_mode = 1;
    push(4'd0, 32'h10); push(4'd2, 32'h20); push(4'd1, 32'h30);
    settle("pre_clear");
    push(4'd8, 32'h0);
    check_eq("clr_not_yet", clear_req, 0);
    step();
    check_eq("clr_pulse", clear_req, 1);
    check_eq("clr_no_cv", cache_valid, 0);
    step();
    check_eq("clr_pulse_end", clear_req, 0);
    check_eq("clr_counters", {reads, writes, hits, misses, bad_cmds}, 40'h0);
    settle("clear");

    // print and illegal codes
    push(4'd9, 32'h1); push(4'd7, 32'h2); push(4'd15, 32'h3);
    settle("print_bad");
    check_eq("bad_abs", bad_cmds, 2);

    // reset while waiting on the cache with records queued
    hold_done = 1; rdy_all = 1;
    push(4'd0, 32'h100); push(4'd1, 32'h104); push(4'd2, 32'h108);
    for (int i = 0; i < 50 && !inflight; i++) step();
    check_eq("mid_inflight", inflight, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_idle", idle, 1);
    check_eq("mid_trc_ready", trc_ready, 1);
    check_eq("mid_cv", cache_valid, 0);
    check_eq("mid_counters", {reads, writes, hits, misses, bad_cmds}, 40'h0);
    hold_done = 0;
    cache_done = 1'b1; hit = 1'b1;
    step();
    cache_done = 1'b0;
    settle("mid_reset");

    // saturation of hits and reads
    hit_mode = 1;
    for (int i = 0; i < MAXC + 4; i++) push(4'd2, 32'(i));
    settle("sat");
    check_eq("sat_hits_abs", hits, MAXC);
    push(4'd8, 32'h0);
    settle("sat_clear");

    // randomized traffic
    rdy_all = 0; hit_mode = 2; spur_en = 1;
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 30; i++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step();
        push(4'($urandom_range(0, 15)), $urandom());
      end
      settle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
